// File: rtl/sobel_grad_mag_pipe.sv
// sobel_grad_mag_pipe: 3-stage Sobel gradient magnitude (L1 or max+min/2) with saturation, edge flag, valid/ready.
// Define SOBEL_GRAD_STATS_EN to add a saturating edge counter (edge_count, cnt_clr).
module sobel_grad_mag_pipe #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8
`ifdef SOBEL_GRAD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] gx,
    input  logic signed [IN_W-1:0] gy,
    input  logic                   mode,
    input  logic [OUT_W-1:0]       threshold,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       g,
    output logic                   edge_out
`ifdef SOBEL_GRAD_STATS_EN
    ,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       edge_count
`endif
);
    localparam logic [IN_W:0] G_MAX = (IN_W+1)'((1 << OUT_W) - 1);

    logic            adv;
    logic [IN_W-1:0] mx, mn;
    logic [IN_W:0]   sum;
    logic [OUT_W-1:0] sat;
    logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, m1_q, m1_d, e_q, e_d;
    logic [IN_W-1:0] ax_q, ax_d, ay_q, ay_d;
    logic [IN_W:0]   s_q, s_d;
    logic [OUT_W-1:0] g_q, g_d;

    // One shared advance keeps the whole pipe in lockstep; bubbles still move forward.
    always_comb begin
        adv  = !v3_q || out_ready;
        mx   = (ax_q >= ay_q) ? ax_q : ay_q;
        mn   = (ax_q >= ay_q) ? ay_q : ax_q;
        sum  = m1_q ? {1'b0, mx} + {1'b0, mn >> 1} : {1'b0, ax_q} + {1'b0, ay_q};
        sat  = (s_q > G_MAX) ? G_MAX[OUT_W-1:0] : s_q[OUT_W-1:0];
        v1_d = adv ? in_valid : v1_q;
        ax_d = adv ? (gx[IN_W-1] ? ~gx + 1'b1 : gx) : ax_q;
        ay_d = adv ? (gy[IN_W-1] ? ~gy + 1'b1 : gy) : ay_q;
        m1_d = adv ? mode : m1_q;
        v2_d = adv ? v1_q : v2_q;
        s_d  = adv ? sum : s_q;
        v3_d = adv ? v2_q : v3_q;
        g_d  = adv ? (v2_q ? sat : '0) : g_q;
        e_d  = adv ? (v2_q && sat >= threshold) : e_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            m1_q <= 1'b0;
            ax_q <= '0;
            ay_q <= '0;
            s_q  <= '0;
            g_q  <= '0;
            e_q  <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            m1_q <= m1_d;
            ax_q <= ax_d;
            ay_q <= ay_d;
            s_q  <= s_d;
            g_q  <= g_d;
            e_q  <= e_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign g         = g_q;
    assign edge_out  = e_q;

`ifdef SOBEL_GRAD_STATS_EN
    logic [CNT_W-1:0] edge_count_q, edge_count_d;

    always_comb begin
        edge_count_d = cnt_clr ? '0 :
                       (v3_q && out_ready && e_q && edge_count_q != '1) ? edge_count_q + 1'b1 : edge_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) edge_count_q <= '0;
        else     edge_count_q <= edge_count_d;
    end

    assign edge_count = edge_count_q;
`endif
endmodule

// File: tb/tb_sobel_grad_mag_pipe.sv
// tb_sobel_grad_mag_pipe: directed vectors with hand-computed magnitudes, checked by a negedge scoreboard.
module tb_sobel_grad_mag_pipe;
    localparam int IN_W  = 11;
    localparam int OUT_W = 8;
`ifdef SOBEL_GRAD_STATS_EN
    localparam int CNT_W = 2;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] edge_count;
`endif
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, edge_out;
    logic signed [IN_W-1:0] gx = '0, gy = '0;
    logic [OUT_W-1:0] threshold = '0, g;
    int n_chk = 0, n_err = 0;
    int exp_q[$];
    int pg, pe, ev;
    logic pst = 1'b0;

    sobel_grad_mag_pipe #(
        .IN_W(IN_W),
        .OUT_W(OUT_W)
`ifdef SOBEL_GRAD_STATS_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .gx(gx),
        .gy(gy),
        .mode(mode),
        .threshold(threshold),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .g(g),
        .edge_out(edge_out)
`ifdef SOBEL_GRAD_STATS_EN
        ,
        .cnt_clr(cnt_clr),
        .edge_count(edge_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every output handshake pops the next hand-computed {g, edge}.
    always @(negedge clk) begin
        if (rst) pst = 1'b0;
        else begin
            if (pst) begin
                chk("hold_v", out_valid, 1);
                chk("hold_g", g, pg);
                chk("hold_e", edge_out, pe);
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (!out_valid) begin
                chk("idle_g", g, 0);
                chk("idle_e", edge_out, 0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) chk("extra_out", 1, 0);
                else begin
                    ev = exp_q.pop_front();
                    chk("g", g, ev >> 1);
                    chk("edge", edge_out, ev & 1);
                end
            end
            pst = out_valid && !out_ready;
            pg  = g;
            pe  = edge_out;
        end
    end

    task automatic send(input int x, input int y, input logic md, input int eg, input logic ee);
        int n = 0;
        logic r;
        gx = IN_W'(x);
        gy = IN_W'(y);
        mode = md;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 50);
        #1;
        if (!r) chk("accept_timeout", 0, 1);
        else exp_q.push_back(eg * 2 + ee);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk("rst_v", out_valid, 0);
        chk("rst_g", g, 0);
        chk("rst_e", edge_out, 0);
        chk("rst_rdy", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        threshold = 8'd1;
        send(0, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clk) chk("lat_c1", out_valid, 0);
        @(negedge clk) chk("lat_c2", out_valid, 0);
        @(negedge clk) chk("lat_c3", out_valid, 1);
        drain();

        threshold = 8'd100;
        send(300, 400, 0, 255, 1);
        send(129, 150, 0, 255, 1);
        send(200, 95, 0, 255, 1);
        send(-40, 30, 0, 70, 0);
        send(-1024, 0, 0, 255, 1);
        send(100, 60, 1, 130, 1);
        send(-60, 100, 1, 130, 1);
        send(255, 255, 1, 255, 1);
        send(7, 3, 1, 8, 0);
        drain();

        threshold = 8'd0;
        send(0, 0, 0, 0, 1);
        send(-1024, -1024, 1, 255, 1);
        send(-1, 1023, 0, 255, 1);
        drain();

        threshold = 8'd50;
        fork
            begin
                send(10, 20, 0, 30, 0);
                send(-5, -5, 0, 10, 0);
                send(30, 30, 0, 60, 1);
                send(100, -1, 0, 101, 1);
                send(0, -50, 0, 50, 1);
                send(1023, 1023, 0, 255, 1);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(1, 2, 0, 3, 0);
        send(3, 4, 0, 7, 0);
        send(5, 6, 0, 11, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rstm_v", out_valid, 0);
        chk("rstm_g", g, 0);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

`ifdef SOBEL_GRAD_STATS_EN
        threshold = 8'd0;
        chk("cnt_rst", edge_count, 0);
        repeat (5) send(5, 5, 0, 10, 1);
        drain();
        chk("cnt_sat", edge_count, 3);
        out_ready = 1'b0;
        send(5, 5, 0, 10, 1);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("cnt_clr", edge_count, 0);
        send(5, 5, 0, 10, 1);
        drain();
        chk("cnt_inc", edge_count, 1);
`endif

        drain();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
